frame_egress_reader: RTL and testbench
======================================

FRAME_EGRESS_READER -- requirements
Module: frame_egress_reader

Interface
REQ-001 Parameter ADDR_WIDTH, default 11, frame-buffer word address width; pointers carry one extra wrap bit.
REQ-002 Parameter DATA_WIDTH, default 8, frame-buffer word and output tdata width.
REQ-003 clk  input  1  sole clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sb_empty  input  1  sideband FIFO holds no entry.
REQ-006 sb_ren  output  1  sideband FIFO pop strobe; sb_rdata is valid the cycle after sb_ren.
REQ-007 sb_rdata  input  20  sideband entry: [`AXIS_DEST_WIDTH-1:0] destination; [ADDR_WIDTH+`AXIS_DEST_WIDTH:`AXIS_DEST_WIDTH] frame end pointer (exclusive); upper bits ignored.
REQ-008 fb_ren  output  1  frame-buffer read strobe.
REQ-009 fb_raddr  output  ADDR_WIDTH  frame-buffer read address; fb_rdata is valid the cycle after fb_ren.
REQ-010 fb_rdata  input  DATA_WIDTH  frame-buffer read data.
REQ-011 fb_rptr  output  ADDR_WIDTH+1  committed read pointer; writer uses it for full detection.
REQ-012 m_tvalid, m_tready, m_tlast  output, input, output  1 each  AXI-stream handshake and end-of-frame.
REQ-013 m_tdata  output  DATA_WIDTH; m_tdest  output  `AXIS_DEST_WIDTH  beat data and frame destination.
REQ-014 frame_count  output  16  frames fully transmitted (see Configuration).

Function
REQ-015 FSM states: IDLE, POP, LOAD, STREAM.
REQ-016 IDLE: when sb_empty=0, assert sb_ren for exactly one cycle and go to POP.
REQ-017 POP: go to LOAD; sb_ren=0.
REQ-018 LOAD: latch destination and end pointer from sb_rdata. If end pointer equals read pointer, discard the zero-length frame, emit no beat, and return to IDLE. Otherwise go to STREAM.
REQ-019 STREAM: issue fb_ren with fb_raddr = read pointer[ADDR_WIDTH-1:0]. Increment the read pointer modulo 2^(ADDR_WIDTH+1) per read. Stop issuing reads when the incremented pointer equals the end pointer.
REQ-020 A 2-entry output skid buffer holds returned words. Issue a read only if occupancy plus in-flight reads is below 2. This sustains one beat per cycle while m_tready=1.
REQ-021 Each beat carries m_tdest = latched destination. m_tlast=1 only on the beat whose address+1 equals the end pointer.
REQ-022 m_tvalid, once asserted, holds with m_tdata, m_tlast and m_tdest stable until m_tready=1.
REQ-023 Return to IDLE only after the tlast beat handshakes. The next sideband pop may then occur on the following cycle.
REQ-024 fb_rptr updates to the end pointer on the cycle after the tlast handshake, never earlier.
REQ-025 Pointer wrap from 2^(ADDR_WIDTH+1)-1 to 0 mid-frame is legal; addresses continue at 0.
REQ-026 sb_ren is never asserted outside IDLE, nor while sb_empty=1.

Reset
REQ-027 On reset: state IDLE, read pointer and fb_rptr 0, skid buffer and in-flight counts cleared, latched destination and end pointer 0.
REQ-028 On reset, all outputs 0: m_tvalid, m_tlast, m_tdata, m_tdest, sb_ren, fb_ren, fb_raddr and frame_count.
REQ-029 Reset asserted mid-frame abandons the frame. m_tvalid is 0 in the cycle after reset is sampled, with no tlast emitted.

Configuration
REQ-030 Macro EGRESS_FRAME_COUNT_EN.
- Defined: frame_count increments by 1, wrapping at 16 bits, on each tlast handshake.
- Undefined: frame_count is constant 0 and no counter logic is synthesized.

Verification
REQ-031 Sideband entry dest=3, end=4 from rptr 0, buffer words 0xA0..0xA3, m_tready=1 -> 4 consecutive beats A0..A3, tdest=3, tlast on A3, fb_rptr=4 after.
REQ-032 Entry end=rptr=7 -> no beat, FSM back to IDLE within 3 cycles, fb_rptr stays 7.
REQ-033 Same 4-word frame with m_tready toggling 1,0,0,1,... -> data order and tlast unchanged, outputs stable while stalled, fb_ren never overruns the skid buffer.
REQ-034 rptr=4094 (ADDR_WIDTH=11), end=2 -> fb_raddr sequence 2046,2047,0,1, tlast on address 1, fb_rptr=2.
REQ-035 Reset asserted after the 2nd beat of a 6-word frame -> m_tvalid=0 next cycle, fb_rptr=0, next frame starts cleanly from pointer 0.
REQ-036 Three back-to-back 2-word frames with EGRESS_FRAME_COUNT_EN defined -> frame_count=3; with it undefined -> frame_count=0.

Source files
------------

// File: rtl/frame_egress_reader_if.sv
// Egress reader bus bundle: sideband FIFO pop port, frame-buffer read port,
// committed read pointer, AXI-stream master and the frame counter.
// The destination width comes from `AXIS_DEST_WIDTH (defaults to 4 here).
`ifndef AXIS_DEST_WIDTH
`define AXIS_DEST_WIDTH 4
`endif

interface frame_egress_reader_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8
);
    // sideband FIFO
    logic                         sb_empty;
    logic                         sb_ren;
    logic [19:0]                  sb_rdata;
    // frame buffer
    logic                         fb_ren;
    logic [ADDR_WIDTH-1:0]        fb_raddr;
    logic [DATA_WIDTH-1:0]        fb_rdata;
    logic [ADDR_WIDTH:0]          fb_rptr;
    // stream out
    logic                         m_tvalid;
    logic                         m_tready;
    logic                         m_tlast;
    logic [DATA_WIDTH-1:0]        m_tdata;
    logic [`AXIS_DEST_WIDTH-1:0]  m_tdest;
    // statistics
    logic [15:0]                  frame_count;

    modport master (
        input  sb_empty, sb_rdata, fb_rdata, m_tready,
        output sb_ren, fb_ren, fb_raddr, fb_rptr,
               m_tvalid, m_tlast, m_tdata, m_tdest, frame_count
    );

    modport slave (
        output sb_empty, sb_rdata, fb_rdata, m_tready,
        input  sb_ren, fb_ren, fb_raddr, fb_rptr,
               m_tvalid, m_tlast, m_tdata, m_tdest, frame_count
    );
endinterface

// File: rtl/frame_egress_reader.sv
// Frame egress reader: pops a {end pointer, destination} descriptor from the
// sideband FIFO, streams the frame-buffer words up to the end pointer as
// AXI-stream beats through a 2-entry skid buffer, then commits fb_rptr.
// Optional feature: define EGRESS_FRAME_COUNT_EN to count transmitted frames;
// otherwise frame_count is tied to 0.
`ifndef AXIS_DEST_WIDTH
`define AXIS_DEST_WIDTH 4
`endif

module frame_egress_reader #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    frame_egress_reader_if.master bus
);
    localparam int PTR_W  = ADDR_WIDTH + 1;
    localparam int DEST_W = `AXIS_DEST_WIDTH;

    typedef enum logic [1:0] {IDLE, POP, LOAD, STREAM} state_t;

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        rptr_q, rptr_d;
    logic [PTR_W-1:0]        fb_rptr_q, fb_rptr_d;
    logic [PTR_W-1:0]        end_q, end_d;
    logic [DEST_W-1:0]       dest_q, dest_d;
    logic                    infl_q, infl_d;          // read issued last cycle, data on fb_rdata now
    logic                    infl_last_q, infl_last_d;
    logic [1:0]              occ_q, occ_d;            // skid buffer occupancy
    logic [DATA_WIDTH-1:0]   skid_data_q [2];
    logic [DATA_WIDTH-1:0]   skid_data_d [2];
    logic                    skid_last_q [2];
    logic                    skid_last_d [2];

    logic                    sb_ren_c;
    logic                    fb_ren_c;
    logic [1:0]              occ_after;
    logic                    beat_pop;
    logic                    frame_done;
    logic                    sb_rdata_unused;

    assign beat_pop        = (occ_q != 2'd0) && bus.m_tready;
    assign frame_done      = beat_pop && skid_last_q[0];
    assign occ_after       = occ_q - {1'b0, beat_pop};
    assign sb_rdata_unused = ^bus.sb_rdata[19:DEST_W+PTR_W];

    // Next-state logic: FSM, read issue with credit check, skid buffer push/pop.
    always_comb begin
        state_d     = state_q;
        rptr_d      = rptr_q;
        fb_rptr_d   = fb_rptr_q;
        end_d       = end_q;
        dest_d      = dest_q;
        infl_d      = 1'b0;
        infl_last_d = 1'b0;
        skid_data_d = skid_data_q;
        skid_last_d = skid_last_q;
        sb_ren_c    = 1'b0;
        fb_ren_c    = 1'b0;

        // Head leaves on handshake; the second entry slides forward.
        if (beat_pop) begin
            skid_data_d[0] = skid_data_q[1];
            skid_last_d[0] = skid_last_q[1];
        end
        // Returning read data lands behind whatever remains after the pop.
        if (infl_q) begin
            skid_data_d[occ_after[0]] = bus.fb_rdata;
            skid_last_d[occ_after[0]] = infl_last_q;
        end
        occ_d = occ_after + {1'b0, infl_q};

        case (state_q)
            IDLE: begin
                if (!bus.sb_empty) begin
                    sb_ren_c = 1'b1;
                    state_d  = POP;
                end
            end
            POP: begin
                // FIFO data is guaranteed valid this cycle, so capture it here
                // and let LOAD work from the held copy.
                dest_d  = bus.sb_rdata[DEST_W-1:0];
                end_d   = bus.sb_rdata[DEST_W +: PTR_W];
                state_d = LOAD;
            end
            LOAD: begin
                state_d = (end_q == rptr_q) ? IDLE : STREAM;
            end
            STREAM: begin
                // Only issue when the word is guaranteed a skid slot.
                if ((rptr_q != end_q) && ((occ_after + {1'b0, infl_q}) < 2'd2)) begin
                    fb_ren_c    = 1'b1;
                    rptr_d      = rptr_q + 1'b1;
                    infl_d      = 1'b1;
                    infl_last_d = ((rptr_q + 1'b1) == end_q);
                end
                if (frame_done) begin
                    state_d   = IDLE;
                    fb_rptr_d = end_q;
                end
            end
            default: state_d = IDLE;
        endcase

        if (reset) begin
            sb_ren_c = 1'b0;
            fb_ren_c = 1'b0;
        end
    end

    // State register with synchronous reset; a reset mid-frame drops everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rptr_q      <= '0;
            fb_rptr_q   <= '0;
            end_q       <= '0;
            dest_q      <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            occ_q       <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                skid_data_q[i] <= '0;
                skid_last_q[i] <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            rptr_q      <= rptr_d;
            fb_rptr_q   <= fb_rptr_d;
            end_q       <= end_d;
            dest_q      <= dest_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
            occ_q       <= occ_d;
            skid_data_q <= skid_data_d;
            skid_last_q <= skid_last_d;
        end
    end

    assign bus.sb_ren   = sb_ren_c;
    assign bus.fb_ren   = fb_ren_c;
    assign bus.fb_raddr = fb_ren_c ? rptr_q[ADDR_WIDTH-1:0] : '0;
    assign bus.fb_rptr  = fb_rptr_q;
    assign bus.m_tvalid = (occ_q != 2'd0);
    assign bus.m_tdata  = skid_data_q[0];
    assign bus.m_tlast  = skid_last_q[0] && (occ_q != 2'd0);
    assign bus.m_tdest  = dest_q;

`ifdef EGRESS_FRAME_COUNT_EN
    logic [15:0] frame_count_q, frame_count_d;

    // Count each completed frame, wrapping at 16 bits.
    always_comb begin
        frame_count_d = frame_count_q + (frame_done ? 16'd1 : 16'd0);
    end

    // Frame counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count_q <= 16'd0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign bus.frame_count = frame_count_q;
`else
    assign bus.frame_count = 16'd0;
`endif

endmodule

// File: tb/tb_frame_egress_reader.sv
// Bench for frame_egress_reader: sideband FIFO and frame-buffer models,
// expected beats queued at descriptor push, checked by a negedge monitor.
`ifndef AXIS_DEST_WIDTH
`define AXIS_DEST_WIDTH 4
`endif

module tb_frame_egress_reader;
    localparam int AW  = 11;
    localparam int DW  = 8;
    localparam int PW  = AW + 1;
    localparam int TDW = `AXIS_DEST_WIDTH;

    typedef struct packed {
        logic [DW-1:0]  data;
        logic           last;
        logic [TDW-1:0] dest;
    } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    frame_egress_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    frame_egress_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    beat_t exp_q[$];
    int    exp_rptr = 0;
    int    beat_cyc_q[$];
    int    sbren_cyc_q[$];
    int    raddr_q[$];
    int    beats_seen = 0;
    int    reads_seen = 0;
    logic [PW-1:0] rd_model = '0;

    logic [19:0]   sb_mem [64];
    int            sb_wr = 0;
    int            sb_rd = 0;
    logic [DW-1:0] fb_mem [1 << AW];

    assign bus.sb_empty = (sb_wr == sb_rd);

    // Sideband FIFO model: data valid the cycle after the pop strobe.
    always @(posedge clk) begin
        if (bus.sb_ren) begin
            bus.sb_rdata <= sb_mem[sb_rd % 64];
            sb_rd        <= sb_rd + 1;
        end
    end

    // Frame buffer model: one-cycle read latency.
    always @(posedge clk) begin
        if (bus.fb_ren) bus.fb_rdata <= fb_mem[bus.fb_raddr];
    end

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Descriptor push: queue the expected beats computed from the buffer content rule.
    task automatic push_frame(input int dest, input int endp);
        logic [19:0] e;
        beat_t b;
        int p;
        p = exp_rptr;
        while (p != endp) begin
            b.data = 8'((p + 160) & 255);
            b.last = (((p + 1) % (1 << PW)) == endp);
            b.dest = TDW'(dest);
            exp_q.push_back(b);
            p = (p + 1) % (1 << PW);
        end
        exp_rptr = endp;
        e = '0;
        e[TDW-1:0]  = TDW'(dest);
        e[TDW +: PW] = PW'(endp);
        sb_mem[sb_wr % 64] = e;
        sb_wr = sb_wr + 1;
    endtask

    task automatic wait_drain(input int maxc, input bit pat);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || sb_wr != sb_rd) && n < maxc) begin
            if (pat) bus.m_tready = ((n % 4) == 0) || ((n % 4) == 3);
            @(posedge clk);
            #1;
            n++;
        end
        bus.m_tready = 1'b1;
        if (n >= maxc) chk("drain_timeout", n, 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor: scoreboard pop on handshake, stall stability, read address and credit checks.
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic [TDW-1:0] prev_dest;
    always @(negedge clk) begin
        beat_t e;
        cyc++;
        if (reset) begin
            prev_stall = 1'b0;
            rd_model   = '0;
            reads_seen = 0;
            beats_seen = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", bus.m_tvalid, 1);
                chk("stall_data", bus.m_tdata, prev_data);
                chk("stall_last", bus.m_tlast, prev_last);
                chk("stall_dest", bus.m_tdest, prev_dest);
            end
            if (bus.sb_ren) begin
                sbren_cyc_q.push_back(cyc);
                chk("sb_ren_while_empty", bus.sb_empty, 0);
            end
            if (bus.fb_ren) begin
                reads_seen++;
                raddr_q.push_back(int'(bus.fb_raddr));
                chk("fb_raddr", bus.fb_raddr, rd_model[AW-1:0]);
                rd_model = rd_model + 1'b1;
            end
            if (bus.m_tvalid && bus.m_tready) begin
                beats_seen++;
                beat_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", bus.m_tdata, -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", bus.m_tdata, e.data);
                    chk("beat_last", bus.m_tlast, e.last);
                    chk("beat_dest", bus.m_tdest, e.dest);
                end
            end
            if (bus.fb_ren) chk("skid_overrun", (reads_seen - beats_seen) > 2, 0);
            prev_stall = bus.m_tvalid && !bus.m_tready;
            prev_data  = bus.m_tdata;
            prev_last  = bus.m_tlast;
            prev_dest  = bus.m_tdest;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        for (int i = 0; i < (1 << AW); i++) fb_mem[i] = 8'((i + 160) & 255);
        bus.m_tready = 1'b1;
        reset = 1'b1;

        // Reset values; a descriptor is already waiting, so sb_ren must stay gated.
        push_frame(3, 4);
        beat_cyc_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_tvalid", bus.m_tvalid, 0);
        chk("rst_m_tlast", bus.m_tlast, 0);
        chk("rst_m_tdata", bus.m_tdata, 0);
        chk("rst_m_tdest", bus.m_tdest, 0);
        chk("rst_sb_ren", bus.sb_ren, 0);
        chk("rst_fb_ren", bus.fb_ren, 0);
        chk("rst_fb_raddr", bus.fb_raddr, 0);
        chk("rst_frame_count", bus.frame_count, 0);
        chk("rst_fb_rptr", bus.fb_rptr, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Basic 4-word frame, full-rate ready.
        wait_drain(200, 1'b0);
        chk("t1_fb_rptr", bus.fb_rptr, 4);
        chk("t1_beat_count", beat_cyc_q.size(), 4);
        if (beat_cyc_q.size() == 4) chk("t1_back_to_back", beat_cyc_q[3] - beat_cyc_q[0], 3);
`ifdef EGRESS_FRAME_COUNT_EN
        chk("t1_frame_count", bus.frame_count, 1);
`else
        chk("t1_frame_count", bus.frame_count, 0);
`endif

        // Advance to 7, then a zero-length descriptor.
        push_frame(1, 7);
        wait_drain(200, 1'b0);
        chk("t2_pre_fb_rptr", bus.fb_rptr, 7);
        push_frame(2, 7);
        wait_drain(200, 1'b0);
        chk("t2_zero_fb_rptr", bus.fb_rptr, 7);

        // Zero-length followed immediately by a 4-word frame under a stalling sink.
        sbren_cyc_q.delete();
        push_frame(2, 7);
        push_frame(3, 11);
        wait_drain(400, 1'b1);
        chk("t3_fb_rptr", bus.fb_rptr, 11);
        chk("t3_pop_count", sbren_cyc_q.size(), 2);
        if (sbren_cyc_q.size() == 2) chk("t3_idle_within_3", (sbren_cyc_q[1] - sbren_cyc_q[0]) <= 3, 1);

        // Reset after the second beat of a 6-word frame.
        push_frame(5, 17);
        base = beats_seen;
        n = 0;
        while (beats_seen < base + 2 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) chk("t4_wait_timeout", n, 0);
        #1;
        reset = 1'b1;
        bus.m_tready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t4_m_tvalid", bus.m_tvalid, 0);
        chk("t4_m_tlast", bus.m_tlast, 0);
        chk("t4_fb_rptr", bus.fb_rptr, 0);
        chk("t4_frame_count", bus.frame_count, 0);
        exp_q.delete();
        exp_rptr = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.m_tready = 1'b1;
        push_frame(6, 3);
        wait_drain(200, 1'b0);
        chk("t4_after_fb_rptr", bus.fb_rptr, 3);

        // Walk the pointer to 4094, then a frame wrapping through zero.
        push_frame(7, 2048);
        wait_drain(5000, 1'b0);
        chk("t5_fb_rptr_a", bus.fb_rptr, 2048);
        push_frame(8, 4094);
        wait_drain(5000, 1'b0);
        chk("t5_fb_rptr_b", bus.fb_rptr, 4094);
        raddr_q.delete();
        push_frame(9, 2);
        wait_drain(200, 1'b0);
        chk("t5_read_count", raddr_q.size(), 4);
        if (raddr_q.size() == 4) begin
            chk("t5_raddr0", raddr_q[0], 2046);
            chk("t5_raddr1", raddr_q[1], 2047);
            chk("t5_raddr2", raddr_q[2], 0);
            chk("t5_raddr3", raddr_q[3], 1);
        end
        chk("t5_fb_rptr", bus.fb_rptr, 2);

        // Three back-to-back 2-word frames.
        push_frame(1, 4);
        push_frame(2, 6);
        push_frame(3, 8);
        wait_drain(300, 1'b0);
        chk("t6_fb_rptr", bus.fb_rptr, 8);
`ifdef EGRESS_FRAME_COUNT_EN
        chk("t6_frame_count", bus.frame_count, 7);
`else
        chk("t6_frame_count", bus.frame_count, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
